// File: rtl/alu_exec_unit.sv
// ALU execution unit: and/or/add/sub/slt/srl on register operands, registered result with valid/ready.
// Latency: 1 edge for logic/arith/illegal ops; srl with shamt=n>0 takes n+1 edges (iterative 1-bit shifter).
// Backpressure: in_ready drops while the shifter runs; requests seen with in_ready=0 are dropped, not queued.
module alu_exec_unit #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         alucontrol,
   input  logic               shiftReg,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               out_valid,
   output logic [WIDTH-1:0]   result,
   output logic               zero,
   output logic               illegal
);

   typedef enum logic {IDLE, SHIFT} state_t;

   localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               zero_q, zero_d;
   logic               illegal_q, illegal_d;
   logic               out_valid_q, out_valid_d;
   logic [WIDTH-1:0]   sreg_q, sreg_d;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;

   logic               accept;
   logic               is_srl;
   logic [WIDTH-1:0]   op_res;
   logic               op_ill;
   logic [WIDTH-1:0]   single_res;
   logic               single_ill;

   // Ready only in IDLE and never while reset is held, so nothing is accepted during reset.
   assign in_ready = reset && (state_q == IDLE);
   assign accept   = in_valid && in_ready;
   assign is_srl   = (alucontrol == 4'b1000) && shiftReg;

   // Single-cycle datapath; unknown codes and shiftReg mismatches fall through to illegal with a zero result.
   always_comb begin
      op_res = '0;
      op_ill = 1'b1;
      case (alucontrol)
         4'b0000: begin op_res = a & b;     op_ill = shiftReg; end
         4'b0001: begin op_res = a | b;     op_ill = shiftReg; end
         4'b0010: begin op_res = a + b;     op_ill = shiftReg; end
         4'b0110: begin op_res = a - b;     op_ill = shiftReg; end
         4'b0111: begin
            op_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            op_ill = shiftReg;
         end
         4'b1000: begin op_res = b;         op_ill = !shiftReg; end
         default: begin op_res = '0;        op_ill = 1'b1; end
      endcase
      single_ill = op_ill;
      single_res = op_ill ? '0 : op_res;
   end

   // Next-state and output-register logic for the IDLE/SHIFT controller.
   always_comb begin
      state_d     = state_q;
      result_d    = result_q;
      zero_d      = zero_q;
      illegal_d   = illegal_q;
      out_valid_d = 1'b0;
      sreg_d      = sreg_q;
      cnt_d       = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (is_srl && (shamt != '0)) begin
                  sreg_d  = b;
                  cnt_d   = shamt;
                  state_d = SHIFT;
               end else begin
                  result_d    = single_res;
                  zero_d      = (single_res == '0);
                  illegal_d   = single_ill;
                  out_valid_d = 1'b1;
               end
            end
         end
         SHIFT: begin
            sreg_d = sreg_q >> 1;
            cnt_d  = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               result_d    = sreg_q >> 1;
               zero_d      = ((sreg_q >> 1) == '0);
               illegal_d   = 1'b0;
               out_valid_d = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset aborts any shift in progress and discards its partial result.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         result_q    <= '0;
         zero_q      <= 1'b0;
         illegal_q   <= 1'b0;
         out_valid_q <= 1'b0;
         sreg_q      <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         illegal_q   <= illegal_d;
         out_valid_q <= out_valid_d;
         sreg_q      <= sreg_d;
         cnt_q       <= cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign zero      = zero_q;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed testbench for alu_exec_unit: one task per scenario with inline expected-value checks.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Requests issued while busy are expected to be dropped.
module tb_alu_exec_unit;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  alucontrol;
   logic        shiftReg;
   logic [31:0] a;
   logic [31:0] b;
   logic [4:0]  shamt;
   logic        out_valid;
   logic [31:0] result;
   logic        zero;
   logic        illegal;

   int pass_cnt;
   int total_cnt;

   alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .alucontrol (alucontrol),
      .shiftReg   (shiftReg),
      .a          (a),
      .b          (b),
      .shamt      (shamt),
      .out_valid  (out_valid),
      .result     (result),
      .zero       (zero),
      .illegal    (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case something wedges the sequence.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] c, input logic s, input logic [31:0] av,
                        input logic [31:0] bv, input logic [4:0] sh);
      alucontrol = c;
      shiftReg   = s;
      a          = av;
      b          = bv;
      shamt      = sh;
      in_valid   = 1'b1;
   endtask

   task automatic test_reset();
      #2;
      total_cnt++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready); else pass_cnt++;
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else pass_cnt++;
      total_cnt++; if (result !== 32'h0) $display("FAIL rst_result: got %h want 0", result); else pass_cnt++;
      total_cnt++; if (zero !== 1'b0 || illegal !== 1'b0) $display("FAIL rst_flags: got zero=%b illegal=%b want 0/0", zero, illegal); else pass_cnt++;
      step();
      reset = 1'b1;
      #1;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL post_rst_in_ready: got %b want 1", in_ready); else pass_cnt++;
      step();
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL post_rst_out_valid: got %b want 0", out_valid); else pass_cnt++;
   endtask

   task automatic test_add_sub();
      drive(4'b0010, 1'b0, 32'd7, 32'd5, 5'd0);
      step();
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL add_valid: got %b want 1", out_valid); else pass_cnt++;
      total_cnt++; if (result !== 32'd12 || zero !== 1'b0) $display("FAIL add_result: got %h z=%b want 0000000c z=0", result, zero); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL add_in_ready: got %b want 1", in_ready); else pass_cnt++;
      drive(4'b0110, 1'b0, 32'd5, 32'd5, 5'd0);
      step();
      in_valid = 1'b0;
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL sub_valid: got %b want 1", out_valid); else pass_cnt++;
      total_cnt++; if (result !== 32'd0 || zero !== 1'b1) $display("FAIL sub_result: got %h z=%b want 0 z=1", result, zero); else pass_cnt++;
      step();
      total_cnt++; if (out_valid !== 1'b0) $display("FAIL sub_single_pulse: got %b want 0", out_valid); else pass_cnt++;
      total_cnt++; if (zero !== 1'b1 || result !== 32'd0) $display("FAIL sub_hold: got %h z=%b want 0 z=1", result, zero); else pass_cnt++;
      // wrap-around add and bitwise ops
      drive(4'b0010, 1'b0, 32'hFFFFFFFF, 32'd2, 5'd0);
      step();
      total_cnt++; if (result !== 32'd1) $display("FAIL add_wrap: got %h want 00000001", result); else pass_cnt++;
      drive(4'b0000, 1'b0, 32'hF0F0_1234, 32'hFF00_00FF, 5'd0);
      step();
      total_cnt++; if (result !== 32'hF000_0034) $display("FAIL and: got %h want f0000034", result); else pass_cnt++;
      drive(4'b0001, 1'b0, 32'hF0F0_1234, 32'h0F00_00FF, 5'd0);
      step();
      in_valid = 1'b0;
      total_cnt++; if (result !== 32'hFFF0_12FF) $display("FAIL or: got %h want fff012ff", result); else pass_cnt++;
   endtask

   task automatic test_slt();
      drive(4'b0111, 1'b0, 32'hFFFFFFFF, 32'd1, 5'd0);
      step();
      total_cnt++; if (result !== 32'd1 || zero !== 1'b0) $display("FAIL slt_neg_lt_pos: got %h z=%b want 1 z=0", result, zero); else pass_cnt++;
      drive(4'b0111, 1'b0, 32'd1, 32'hFFFFFFFF, 5'd0);
      step();
      in_valid = 1'b0;
      total_cnt++; if (result !== 32'd0 || zero !== 1'b1) $display("FAIL slt_pos_lt_neg: got %h z=%b want 0 z=1", result, zero); else pass_cnt++;
      step();
   endtask

   task automatic test_srl_busy();
      drive(4'b1000, 1'b1, 32'd0, 32'h8000_0000, 5'd4);
      step();
      // junk request during busy must be ignored
      drive(4'b0010, 1'b0, 32'd1, 32'd1, 5'd0);
      for (int i = 0; i < 4; i++) begin
         total_cnt++; if (in_ready !== 1'b0 || out_valid !== 1'b0) $display("FAIL srl_busy_%0d: got rdy=%b vld=%b want 0/0", i, in_ready, out_valid); else pass_cnt++;
         step();
      end
      in_valid = 1'b0;
      total_cnt++; if (out_valid !== 1'b1) $display("FAIL srl4_valid: got %b want 1", out_valid); else pass_cnt++;
      total_cnt++; if (result !== 32'h0800_0000 || illegal !== 1'b0 || zero !== 1'b0) $display("FAIL srl4_result: got %h il=%b z=%b want 08000000 0 0", result, illegal, zero); else pass_cnt++;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL srl4_ready: got %b want 1", in_ready); else pass_cnt++;
      step();
      total_cnt++; if (out_valid !== 1'b0 || result !== 32'h0800_0000) $display("FAIL srl4_no_queue: got vld=%b res=%h want 0 08000000", out_valid, result); else pass_cnt++;
   endtask

   task automatic test_srl_edges();
      int n;
      drive(4'b1000, 1'b1, 32'd0, 32'h0000_1234, 5'd0);
      step();
      in_valid = 1'b0;
      total_cnt++; if (out_valid !== 1'b1 || result !== 32'h1234) $display("FAIL srl0: got vld=%b res=%h want 1 00001234", out_valid, result); else pass_cnt++;
      drive(4'b1000, 1'b1, 32'd0, 32'hFFFF_FFFF, 5'd31);
      step();
      in_valid = 1'b0;
      n = 1;
      while (out_valid !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      total_cnt++; if (n !== 32) $display("FAIL srl31_latency: got %0d edges want 32", n); else pass_cnt++;
      total_cnt++; if (result !== 32'd1) $display("FAIL srl31_result: got %h want 00000001", result); else pass_cnt++;
      step();
   endtask

   task automatic test_illegal();
      drive(4'b0011, 1'b0, 32'd9, 32'd9, 5'd0);
      step();
      total_cnt++; if (out_valid !== 1'b1 || illegal !== 1'b1 || result !== 32'd0 || zero !== 1'b1) $display("FAIL ill_code: got vld=%b il=%b res=%h z=%b want 1 1 0 1", out_valid, illegal, result, zero); else pass_cnt++;
      drive(4'b0010, 1'b0, 32'd3, 32'd4, 5'd0);
      step();
      total_cnt++; if (illegal !== 1'b0 || result !== 32'd7) $display("FAIL ill_clear: got il=%b res=%h want 0 7", illegal, result); else pass_cnt++;
      drive(4'b0010, 1'b1, 32'd3, 32'd4, 5'd0);
      step();
      total_cnt++; if (out_valid !== 1'b1 || illegal !== 1'b1 || result !== 32'd0 || zero !== 1'b1) $display("FAIL ill_shiftreg: got vld=%b il=%b res=%h z=%b want 1 1 0 1", out_valid, illegal, result, zero); else pass_cnt++;
      drive(4'b1000, 1'b0, 32'd0, 32'hF0, 5'd2);
      step();
      in_valid = 1'b0;
      total_cnt++; if (out_valid !== 1'b1 || illegal !== 1'b1 || result !== 32'd0) $display("FAIL ill_srl_noshift: got vld=%b il=%b res=%h want 1 1 0", out_valid, illegal, result); else pass_cnt++;
      step();
   endtask

   task automatic test_reset_mid_shift();
      int seen;
      drive(4'b0010, 1'b0, 32'd20, 32'd22, 5'd0);
      step();
      drive(4'b1000, 1'b1, 32'd0, 32'hFF00_0000, 5'd8);
      step();
      in_valid = 1'b0;
      step();
      reset = 1'b0;
      #1;
      total_cnt++; if (result !== 32'd0 || zero !== 1'b0 || illegal !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) $display("FAIL mid_rst_outputs: got res=%h z=%b il=%b vld=%b rdy=%b want all 0", result, zero, illegal, out_valid, in_ready); else pass_cnt++;
      step();
      step();
      #2;
      reset = 1'b1;
      #1;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL after_rst_ready: got %b want 1", in_ready); else pass_cnt++;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (out_valid === 1'b1) seen++;
      end
      total_cnt++; if (seen !== 0) $display("FAIL aborted_no_pulse: got %0d pulses want 0", seen); else pass_cnt++;
      drive(4'b0010, 1'b0, 32'd1, 32'd1, 5'd0);
      step();
      in_valid = 1'b0;
      total_cnt++; if (out_valid !== 1'b1 || result !== 32'd2) $display("FAIL after_rst_add: got vld=%b res=%h want 1 2", out_valid, result); else pass_cnt++;
   endtask

   initial begin
      pass_cnt   = 0;
      total_cnt  = 0;
      reset      = 1'b0;
      in_valid   = 1'b0;
      alucontrol = 4'b0000;
      shiftReg   = 1'b0;
      a          = 32'd0;
      b          = 32'd0;
      shamt      = 5'd0;
      test_reset();
      test_add_sub();
      test_slt();
      test_srl_busy();
      test_srl_edges();
      test_illegal();
      test_reset_mid_shift();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution-side consumer of the ALU decoder's control word (alucontrol[3:0], shiftReg).
- Performs the decoded operation on register operands and returns a registered result with a valid/ready handshake.
- Logic ops complete in one cycle. srl uses an iterative 1-bit-per-cycle shifter, so the datapath avoids a barrel shifter and the unit has variable latency.
- Sits between the decode stage and the writeback mux of the multi-cycle datapath.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SHAMT_W, 5, shift-amount width; must satisfy 2**SHAMT_W <= WIDTH.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  unit can accept a request this cycle.
- alucontrol  input  4  decoded op: 0000 and, 0001 or, 0010 add, 0110 sub, 0111 slt, 1000 srl.
- shiftReg  input  1  shift-path select; must be 1 exactly when alucontrol=1000.
- a  input  WIDTH  operand A (rs).
- b  input  WIDTH  operand B (rt/immediate); srl shifts b.
- shamt  input  SHAMT_W  shift amount for srl.
- out_valid  output  1  one-cycle pulse: result/zero/illegal are new.
- result  output  WIDTH  registered result, held until the next completion.
- zero  output  1  result==0, registered with result.
- illegal  output  1  registered with result; 1 = unsupported/inconsistent control word.

Behaviour:
- Reset (reset=0, async): state=IDLE; result=0, zero=0, illegal=0, out_valid=0, in_ready=0 while asserted. After deassertion, in_ready=1 from the first cycle.
- Accept occurs on a rising edge where in_valid & in_ready. Inputs are sampled only at accept. in_valid while in_ready=0 is ignored, and no request is queued.
- States: IDLE, SHIFT.
- IDLE, accepted single-cycle op (and/or/add/sub/slt, srl with shamt=0, illegal code):
  - result, zero and illegal are written at the accept edge.
  - out_valid=1 for the following cycle.
  - State stays IDLE, so throughput is 1 op/cycle.
- IDLE, accepted srl with shamt=n>0:
  - Load sreg=b and cnt=n; go to SHIFT; in_ready=0.
- SHIFT, each edge:
  - sreg = sreg>>1 (zero-fill); cnt = cnt-1.
  - On the edge where cnt goes 1->0: result=sreg>>1, update zero, illegal=0, out_valid=1 next cycle, return to IDLE.
  - srl latency is therefore n+1 edges from accept to out_valid.
  - in_ready=1 in the out_valid cycle, so a back-to-back accept is allowed.
- Arithmetic:
  - add/sub wrap modulo 2**WIDTH; no overflow flag.
  - slt is a signed compare: result = {WIDTH-1 zeros, (a<b signed)}.
  - and/or are bitwise.
- Illegal: any alucontrol not listed above, or shiftReg inconsistent with alucontrol. Effect: result=0, zero=1, illegal=1, single-cycle completion.
- X inputs on alucontrol at accept are treated as illegal; result must not go X.
- out_valid is never asserted for two cycles from one request. Outputs are stable between pulses.
- Reset asserted mid-SHIFT: abort immediately. The partial result is discarded and no out_valid pulse is produced.

Test Plan:
- add a=7, b=5 (0010/0) -> next cycle out_valid=1, result=12, zero=0. Then sub a=5, b=5 (0110/0) back-to-back -> result=0, zero=1.
- slt a=0xFFFFFFFF, b=1 (0111/0) -> result=1. slt a=1, b=0xFFFFFFFF -> result=0.
- srl b=0x80000000, shamt=4 (1000/1) -> in_ready=0 for 4 cycles, out_valid on the 5th cycle after accept, result=0x08000000. in_valid pulses during busy are ignored.
- srl shamt=0, b=0x1234 -> single-cycle, result=0x1234. srl shamt=31, b=0xFFFFFFFF -> result=1 after 32 edges.
- Illegal: alucontrol=0011, or alucontrol=0010 with shiftReg=1 -> out_valid=1, illegal=1, result=0, zero=1.
- reset pulled low on cycle 2 of srl shamt=8 -> all outputs 0 immediately, no out_valid. After release, in_ready=1 and add 1+1 gives 2.
